// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: latches level/edge requests, presents one masked winner
// to the core, tracks it through service and pulses a per-source finish line on mret.
module irq_arbiter #(
  parameter int unsigned N_IRQ = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] int_req_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic [N_IRQ-1:0] edge_sel_i,
  input  logic             int_ack_i,
  input  logic             int_rst_i,
  output logic             irq_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] int_fin_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] req_prev_q;
  logic [N_IRQ-1:0] int_fin_q, int_fin_d;
  logic [N_IRQ-1:0] eligible;
  logic [4:0]       sel_id_q, sel_id_d;
  logic [4:0]       winner;
  logic             any_eligible;
  logic             sel_eligible;
  logic             complete;

  assign eligible     = pending_q & mie_i;
  assign any_eligible = |eligible;
  assign complete     = (state_q == StService) && int_rst_i;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 5'(i);
    end
  end

  always_comb begin
    sel_eligible = 1'b0;
    int_fin_d    = '0;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (sel_id_q == 5'(i)) begin
        sel_eligible = eligible[i];
        int_fin_d[i] = complete;
      end
    end
  end

  // Edge sources: a new edge wins over the completion clear so it is never dropped.
  assign pending_d = (int_req_i & ~edge_sel_i)
                   | (edge_sel_i & ((int_req_i & ~req_prev_q) | (pending_q & ~int_fin_d)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_q  <= '0;
      req_prev_q <= '0;
      int_fin_q  <= '0;
      sel_id_q   <= '0;
    end else begin
      pending_q  <= pending_d;
      req_prev_q <= int_req_i;
      int_fin_q  <= int_fin_d;
      sel_id_q   <= sel_id_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_id_d = sel_id_q;
    unique case (state_q)
      StIdle: begin
        if (any_eligible) begin
          sel_id_d = winner;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (int_ack_i) begin
          state_d = StService;
        end else if (!sel_eligible) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (int_rst_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    irq_o  = (state_q == StReq);
    busy_o = (state_q != StIdle);
  end

  assign mcause_o  = {1'b1, 26'b0, sel_id_q};
  assign int_fin_o = int_fin_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level reference model.
module tb_irq_arbiter;

  localparam int N = 32;
  localparam int PhIdle = 0, PhPresent = 1, PhService = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  int_req_i, mie_i, edge_sel_i;
  logic          int_ack_i, int_rst_i;
  logic          irq_o, busy_o;
  logic [31:0]   mcause_o;
  logic [N-1:0]  int_fin_o;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pend, m_prev, m_fin;
  int          m_sel, m_phase;

  irq_arbiter #(.N_IRQ(N)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .int_req_i  (int_req_i),
    .mie_i      (mie_i),
    .edge_sel_i (edge_sel_i),
    .int_ack_i  (int_ack_i),
    .int_rst_i  (int_rst_i),
    .irq_o      (irq_o),
    .mcause_o   (mcause_o),
    .int_fin_o  (int_fin_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_fin = '0; m_sel = 0; m_phase = PhIdle;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".irq"}, {31'b0, irq_o}, {31'b0, m_phase == PhPresent});
    check({tag, ".busy"}, {31'b0, busy_o}, {31'b0, m_phase != PhIdle});
    check({tag, ".mcause"}, mcause_o, 32'h8000_0000 + 32'(m_sel));
    check({tag, ".fin"}, int_fin_o, m_fin);
  endtask

  // Advance one clock: predict from pre-edge inputs, commit at the edge, compare after it.
  task automatic step(input string tag);
    logic [31:0] elig, clr, n_pend;
    int          w, n_sel, n_phase;
    elig = m_pend & mie_i;
    w = -1;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) begin
        w = i;
        break;
      end
    end
    clr = (m_phase == PhService && int_rst_i) ? (32'd1 << m_sel) : 32'd0;
    n_pend = (int_req_i & ~edge_sel_i)
           | (edge_sel_i & ((int_req_i & ~m_prev) | (m_pend & ~clr)));
    n_sel = m_sel;
    n_phase = m_phase;
    case (m_phase)
      PhIdle:    if (w >= 0) begin n_sel = w; n_phase = PhPresent; end
      PhPresent: if (int_ack_i) n_phase = PhService;
                 else if (!elig[m_sel]) n_phase = PhIdle;
      default:   if (int_rst_i) n_phase = PhIdle;
    endcase
    @(posedge clk_i);
    if (rst_i) begin
      m_pend = n_pend; m_prev = int_req_i; m_fin = clr; m_sel = n_sel; m_phase = n_phase;
    end else begin
      model_reset();
    end
    #1;
    compare_model(tag);
  endtask

  initial begin
    rst_i = 1'b0; int_req_i = '0; mie_i = '0; edge_sel_i = '0;
    int_ack_i = 1'b0; int_rst_i = 1'b0;
    model_reset();

    // 1: reset values
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_mcause", mcause_o, 32'h8000_0000);
    check("rst_fin", int_fin_o, 32'd0);
    step("idle");

    // 2: single level source 3
    mie_i = 32'h8; int_req_i = 32'h8;
    step("t2a");
    check("t2_irq_early", {31'b0, irq_o}, 32'd0);
    step("t2b");
    check("t2_irq", {31'b0, irq_o}, 32'd1);
    check("t2_mcause", mcause_o, 32'h8000_0003);
    int_ack_i = 1'b1; step("t2ack"); int_ack_i = 1'b0;
    check("t2_busy", {31'b0, busy_o}, 32'd1);
    check("t2_irq_ack", {31'b0, irq_o}, 32'd0);
    int_req_i = '0; step("t2c");
    int_rst_i = 1'b1; step("t2rst"); int_rst_i = 1'b0;
    check("t2_fin", int_fin_o, 32'h0000_0008);
    step("t2d");
    check("t2_fin_off", int_fin_o, 32'd0);

    // 3: priority between 5 and 2, then 5 follows
    mie_i = '1; int_req_i = 32'h24;
    step("t3a"); step("t3b");
    check("t3_mcause2", mcause_o, 32'h8000_0002);
    int_ack_i = 1'b1; int_req_i = 32'h20; step("t3ack"); int_ack_i = 1'b0;
    int_rst_i = 1'b1; step("t3rst"); int_rst_i = 1'b0;
    check("t3_fin", int_fin_o, 32'h0000_0004);
    step("t3c");
    check("t3_irq5", {31'b0, irq_o}, 32'd1);
    check("t3_mcause5", mcause_o, 32'h8000_0005);
    int_ack_i = 1'b1; int_req_i = '0; step("t3ack2"); int_ack_i = 1'b0;
    int_rst_i = 1'b1; step("t3rst2"); int_rst_i = 1'b0;
    step("t3d");

    // 4: edge source 7 pulsed during service of source 1
    edge_sel_i = 32'h80; int_req_i = 32'h2;
    step("t4a"); step("t4b");
    int_ack_i = 1'b1; step("t4ack"); int_ack_i = 1'b0;
    int_req_i = '0; step("t4c");
    int_req_i = 32'h80; step("t4pulse"); int_req_i = '0;
    step("t4d"); step("t4e");
    check("t4_no_irq", {31'b0, irq_o}, 32'd0);
    check("t4_busy", {31'b0, busy_o}, 32'd1);
    int_rst_i = 1'b1; step("t4rst"); int_rst_i = 1'b0;
    check("t4_fin1", int_fin_o, 32'h0000_0002);
    step("t4f");
    check("t4_irq7", {31'b0, irq_o}, 32'd1);
    check("t4_mcause7", mcause_o, 32'h8000_0007);
    int_ack_i = 1'b1; step("t4ack7"); int_ack_i = 1'b0;
    int_rst_i = 1'b1; step("t4rst7"); int_rst_i = 1'b0;
    check("t4_fin7", int_fin_o, 32'h0000_0080);
    step("t4g");
    check("t4_idle", {31'b0, busy_o}, 32'd0);

    // 5: withdrawal by masking, no preemption by source 0
    edge_sel_i = '0; int_req_i = 32'h10;
    step("t5a"); step("t5b");
    check("t5_mcause4", mcause_o, 32'h8000_0004);
    int_req_i = 32'h11; step("t5c");
    check("t5_nopreempt", mcause_o, 32'h8000_0004);
    check("t5_irq_held", {31'b0, irq_o}, 32'd1);
    mie_i = ~32'h10; step("t5mask");
    check("t5_irq_drop", {31'b0, irq_o}, 32'd0);
    check("t5_busy_drop", {31'b0, busy_o}, 32'd0);
    check("t5_no_fin", int_fin_o, 32'd0);
    check("t5_mcause_hold", mcause_o, 32'h8000_0004);
    step("t5d");
    check("t5_mcause0", mcause_o, 32'h8000_0000);
    check("t5_irq0", {31'b0, irq_o}, 32'd1);
    int_ack_i = 1'b1; int_req_i = '0; step("t5ack"); int_ack_i = 1'b0;
    int_rst_i = 1'b1; step("t5rst"); int_rst_i = 1'b0;
    mie_i = '1; step("t5e");

    // 6: reset coinciding with completion
    int_req_i = 32'h40;
    step("t6a"); step("t6b");
    int_ack_i = 1'b1; step("t6ack"); int_ack_i = 1'b0;
    int_req_i = '0; step("t6c");
    int_rst_i = 1'b1; rst_i = 1'b0;
    #1;
    model_reset();
    check("t6_irq", {31'b0, irq_o}, 32'd0);
    check("t6_busy", {31'b0, busy_o}, 32'd0);
    check("t6_mcause", mcause_o, 32'h8000_0000);
    check("t6_fin", int_fin_o, 32'd0);
    int_rst_i = 1'b0;
    step("t6rst1"); step("t6rst2");
    rst_i = 1'b1;
    step("t6e");
    check("t6_fin_after", int_fin_o, 32'd0);

    // Randomized traffic against the model
    edge_sel_i = $urandom;
    for (int c = 0; c < 600; c++) begin
      int_req_i = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 15) == 0) mie_i = $urandom | $urandom;
      int_ack_i = ($urandom_range(0, 2) == 0);
      int_rst_i = ($urandom_range(0, 2) == 0);
      if (c % 150 == 149) edge_sel_i = $urandom;
      rst_i = ($urandom_range(0, 199) != 0);
      if (!rst_i) begin
        #1;
        model_reset();
        compare_model("rnd_async");
      end
      step("rnd");
      rst_i = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
